// File: rtl/ascon_pack.sv
// Shared types for the ASCON host-side block sequencer: block tags, FSM states, buffer entry width.
package ascon_pack;

  localparam int ASCON_RATE_W = 64;
  localparam int BLK_META_W   = 3;
  localparam int BLK_ENTRY_W  = ASCON_RATE_W + BLK_META_W;

  typedef enum logic [1:0] {
    BLK_AD = 2'b00,
    BLK_PT = 2'b01
  } blk_type_t;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_START  = 4'd1,
    S_W_INIT = 4'd2,
    S_AD     = 4'd3,
    S_W_DA   = 4'd4,
    S_PT     = 4'd5,
    S_W_TC   = 4'd6,
    S_FIN    = 4'd7,
    S_W_FIN  = 4'd8,
    S_TAG    = 4'd9,
    S_ERR    = 4'd10
  } seq_state_t;

endpackage

// File: rtl/ascon_blk_fifo.sv
// Synchronous FIFO with registered pointers; head is a direct read of the oldest entry (0-cycle peek).
// Pushes while full and pops while empty are dropped; flush empties it in one cycle.
module ascon_blk_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 67
) (
  input  logic             clock_i,
  input  logic             resetb_i,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clock_i) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ascon_block_sequencer.sv
// Host-side scheduler for the ASCON core: buffers AD/PT blocks, issues them when the core is parked
// in the matching phase (pulses one cycle after the decision); host is stalled by blk_ready_o.
module ascon_block_sequencer
  import ascon_pack::*;
#(
  parameter int DATA_W     = 64,
  parameter int TAG_W      = 128,
  parameter int FIFO_DEPTH = 2,
  parameter int NUM_AD_BLK = 1,
  parameter int NUM_PT_BLK = 2
) (
  input  logic              clock_i,
  input  logic              resetb_i,
  input  logic              start_i,
  input  logic              blk_valid_i,
  output logic              blk_ready_o,
  input  logic [DATA_W-1:0] blk_data_i,
  input  logic [1:0]        blk_type_i,
  input  logic              blk_last_i,
  output logic              core_start_o,
  output logic              core_data_valid_o,
  output logic [DATA_W-1:0] core_data_o,
  input  logic              core_end_init_i,
  input  logic              core_end_da_i,
  input  logic              core_end_tc_i,
  input  logic              core_end_final_i,
  input  logic              core_cipher_vld_i,
  input  logic [DATA_W-1:0] core_cipher_i,
  input  logic [TAG_W-1:0]  core_tag_i,
  output logic              ct_valid_o,
  output logic [DATA_W-1:0] ct_data_o,
  output logic              tag_valid_o,
  output logic [TAG_W-1:0]  tag_o,
  output logic              busy_o,
  output logic              err_o
);

  localparam int ENTRY_W = DATA_W + (BLK_ENTRY_W - ASCON_RATE_W);
  localparam int AD_CW   = $clog2(NUM_AD_BLK + 1);
  localparam int PT_CW   = $clog2(NUM_PT_BLK + 1);
  localparam logic [AD_CW-1:0] AD_LAST = AD_CW'(NUM_AD_BLK - 1);
  localparam logic [PT_CW-1:0] PT_LAST = PT_CW'(NUM_PT_BLK - 1);
  localparam logic [PT_CW-1:0] PT_N    = PT_CW'(NUM_PT_BLK);

  seq_state_t        state, state_nx;
  logic              end_init_q, end_da_q, end_tc_q;
  logic              rise_init, rise_da, rise_tc;
  logic [AD_CW-1:0]  ad_cnt;
  logic [PT_CW-1:0]  pt_cnt;
  logic              fifo_full, fifo_empty, fifo_push, fifo_pop, fifo_flush;
  logic [ENTRY_W-1:0] fifo_head;
  blk_type_t         head_type;
  logic              head_last;
  logic [DATA_W-1:0] head_data;
  logic              issue, start_go, err_set, ad_inc, pt_inc;
  logic [DATA_W-1:0] issue_data;

  assign busy_o      = (state != S_IDLE) && (state != S_ERR);
  assign blk_ready_o = !fifo_full && busy_o;
  assign fifo_push   = blk_valid_i && blk_ready_o;

  assign head_type = blk_type_t'(fifo_head[ENTRY_W-1 -: 2]);
  assign head_last = fifo_head[DATA_W];
  assign head_data = fifo_head[DATA_W-1:0];

  // Edge detection keeps a phase level left over from the previous step from re-triggering.
  assign rise_init = core_end_init_i && !end_init_q;
  assign rise_da   = core_end_da_i && !end_da_q;
  assign rise_tc   = core_end_tc_i && !end_tc_q;

  ascon_blk_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clock_i   (clock_i),
    .resetb_i  (resetb_i),
    .flush     (fifo_flush),
    .push      (fifo_push),
    .push_data ({blk_type_i, blk_last_i, blk_data_i}),
    .pop       (fifo_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  always_comb begin
    state_nx   = state;
    issue      = 1'b0;
    issue_data = head_data;
    fifo_pop   = 1'b0;
    fifo_flush = 1'b0;
    start_go   = 1'b0;
    err_set    = 1'b0;
    ad_inc     = 1'b0;
    pt_inc     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_i) begin
          start_go = 1'b1;
          state_nx = S_START;
        end
      end
      S_START:  state_nx = S_W_INIT;
      S_W_INIT: if (rise_init) state_nx = S_AD;
      S_AD: begin
        if (!fifo_empty) begin
          if (head_type != BLK_AD || head_last != (ad_cnt == AD_LAST)) begin
            err_set = 1'b1;
          end else if (core_end_init_i) begin
            fifo_pop = 1'b1;
            issue    = 1'b1;
            ad_inc   = 1'b1;
            state_nx = (ad_cnt == AD_LAST) ? S_W_DA : S_W_INIT;
          end
        end
      end
      S_W_DA: if (rise_da) state_nx = S_PT;
      S_PT: begin
        if (!fifo_empty) begin
          if (head_type != BLK_PT || head_last != (pt_cnt == PT_LAST)) begin
            err_set = 1'b1;
          end else if ((pt_cnt == '0) ? core_end_da_i : core_end_tc_i) begin
            fifo_pop = 1'b1;
            issue    = 1'b1;
            pt_inc   = 1'b1;
            state_nx = S_W_TC;
          end
        end
      end
      S_W_TC: if (rise_tc) state_nx = (pt_cnt < PT_N) ? S_PT : S_FIN;
      S_FIN: begin
        issue      = 1'b1;
        issue_data = '0;
        state_nx   = S_W_FIN;
      end
      S_W_FIN: if (core_end_final_i) state_nx = S_TAG;
      S_TAG:   state_nx = S_IDLE;
      S_ERR: begin
        fifo_flush = 1'b1;
        if (start_i) begin
          start_go = 1'b1;
          state_nx = S_START;
        end
      end
      default: state_nx = S_IDLE;
    endcase
    // Ciphertext is only legitimate while the core is processing a text block.
    if (core_cipher_vld_i && state != S_W_TC && state != S_ERR) err_set = 1'b1;
    if (err_set) begin
      state_nx = S_ERR;
      fifo_pop = 1'b0;
      issue    = 1'b0;
      start_go = 1'b0;
      ad_inc   = 1'b0;
      pt_inc   = 1'b0;
    end
    if (start_go) fifo_flush = 1'b1;
  end

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state             <= S_IDLE;
      end_init_q        <= 1'b0;
      end_da_q          <= 1'b0;
      end_tc_q          <= 1'b0;
      ad_cnt            <= '0;
      pt_cnt            <= '0;
      core_start_o      <= 1'b0;
      core_data_valid_o <= 1'b0;
      core_data_o       <= '0;
      ct_valid_o        <= 1'b0;
      ct_data_o         <= '0;
      tag_valid_o       <= 1'b0;
      tag_o             <= '0;
      err_o             <= 1'b0;
    end else begin
      state             <= state_nx;
      end_init_q        <= core_end_init_i;
      end_da_q          <= core_end_da_i;
      end_tc_q          <= core_end_tc_i;
      core_start_o      <= start_go;
      core_data_valid_o <= issue;
      if (issue) core_data_o <= issue_data;
      ct_valid_o        <= core_cipher_vld_i;
      if (core_cipher_vld_i) ct_data_o <= core_cipher_i;
      tag_valid_o       <= (state == S_TAG);
      if (start_go)            tag_o <= '0;
      else if (state == S_TAG) tag_o <= core_tag_i;
      if (err_set)       err_o <= 1'b1;
      else if (start_go) err_o <= 1'b0;
      if (start_go) begin
        ad_cnt <= '0;
        pt_cnt <= '0;
      end else begin
        if (ad_inc) ad_cnt <= ad_cnt + 1'b1;
        if (pt_inc) pt_cnt <= pt_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ascon_block_sequencer.sv
// Directed bench: the initial block plays host and core; pulses are counted on the falling edge.
module tb_ascon_block_sequencer;
  import ascon_pack::*;

  logic         clock_i = 1'b0;
  logic         resetb_i = 1'b0;
  logic         start_i = 1'b0;
  logic         blk_valid_i = 1'b0;
  logic         blk_ready_o;
  logic [63:0]  blk_data_i = '0;
  logic [1:0]   blk_type_i = '0;
  logic         blk_last_i = 1'b0;
  logic         core_start_o, core_data_valid_o;
  logic [63:0]  core_data_o;
  logic         core_end_init_i = 1'b0, core_end_da_i = 1'b0, core_end_tc_i = 1'b0;
  logic         core_end_final_i = 1'b0, core_cipher_vld_i = 1'b0;
  logic [63:0]  core_cipher_i = '0;
  logic [127:0] core_tag_i = '0;
  logic         ct_valid_o, tag_valid_o, busy_o, err_o;
  logic [63:0]  ct_data_o;
  logic [127:0] tag_o;

  int checks = 0, errors = 0;
  int n_start = 0, n_dv = 0, n_ct = 0, n_tag = 0;
  logic [63:0] dv_log[$];
  logic [63:0] ct_log[$];

  ascon_block_sequencer dut (
    .clock_i(clock_i), .resetb_i(resetb_i), .start_i(start_i),
    .blk_valid_i(blk_valid_i), .blk_ready_o(blk_ready_o), .blk_data_i(blk_data_i),
    .blk_type_i(blk_type_i), .blk_last_i(blk_last_i),
    .core_start_o(core_start_o), .core_data_valid_o(core_data_valid_o), .core_data_o(core_data_o),
    .core_end_init_i(core_end_init_i), .core_end_da_i(core_end_da_i), .core_end_tc_i(core_end_tc_i),
    .core_end_final_i(core_end_final_i), .core_cipher_vld_i(core_cipher_vld_i),
    .core_cipher_i(core_cipher_i), .core_tag_i(core_tag_i),
    .ct_valid_o(ct_valid_o), .ct_data_o(ct_data_o), .tag_valid_o(tag_valid_o), .tag_o(tag_o),
    .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clock_i = ~clock_i;

  always @(negedge clock_i) begin
    if (core_start_o) n_start++;
    if (core_data_valid_o) begin
      n_dv++;
      dv_log.push_back(core_data_o);
    end
    if (ct_valid_o) begin
      n_ct++;
      ct_log.push_back(ct_data_o);
    end
    if (tag_valid_o) n_tag++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clock_i);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [63:0] d, input logic [1:0] ty, input logic last);
    logic acc = 1'b0;
    blk_data_i  = d;
    blk_type_i  = ty;
    blk_last_i  = last;
    blk_valid_i = 1'b1;
    for (int k = 0; k < 100 && !acc; k++) begin
      acc = blk_ready_o;
      tick(1);
    end
    blk_valid_i = 1'b0;
    chk("push_accept", acc, 1);
  endtask

  task automatic wait_dv(input int n);
    for (int k = 0; k < 200 && n_dv < n; k++) tick(1);
    chk("dv_count", n_dv, n);
  endtask

  task automatic wait_tag(input int n);
    for (int k = 0; k < 200 && n_tag < n; k++) tick(1);
    chk("tag_count", n_tag, n);
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    tick(1);
    start_i = 1'b0;
    chk("start_pulse", core_start_o, 1);
    chk("start_clears_err", err_o, 0);
    chk("start_busy", busy_o, 1);
  endtask

  task automatic run_msg(input logic [63:0] ad, input logic [63:0] p1, input logic [63:0] p2,
                         input logic [63:0] c1, input logic [63:0] c2, input logic [127:0] tg,
                         input int gap, input bit stall_chk, input bit hold_tc);
    int s0 = n_start, d0 = n_dv, c0 = n_ct, t0 = n_tag;
    pulse_start();
    push(ad, BLK_AD, 1'b1);
    push(p1, BLK_PT, 1'b0);
    if (stall_chk) begin
      blk_data_i = p2; blk_type_i = BLK_PT; blk_last_i = 1'b1; blk_valid_i = 1'b1;
      tick(1);
      chk("third_push_stalls", blk_ready_o, 0);
    end
    core_end_init_i = 1'b1;
    if (gap == 0) push(p2, BLK_PT, 1'b1);
    wait_dv(d0 + 1);
    core_end_init_i = 1'b0;
    core_end_da_i   = 1'b1;
    wait_dv(d0 + 2);
    core_end_da_i = 1'b0;
    core_cipher_vld_i = 1'b1; core_cipher_i = c1;
    tick(1);
    core_cipher_vld_i = 1'b0;
    core_end_tc_i = 1'b1;
    tick(1);
    if (gap > 0) begin
      tick(gap);
      chk("stall_no_issue", n_dv, d0 + 2);
      chk("stall_no_err", err_o, 0);
      push(p2, BLK_PT, 1'b1);
    end
    wait_dv(d0 + 3);
    if (hold_tc) begin
      core_cipher_vld_i = 1'b1; core_cipher_i = c2;
      tick(1);
      core_cipher_vld_i = 1'b0;
      tick(10);
      chk("level_guard_no_issue", n_dv, d0 + 3);
      chk("level_guard_busy", busy_o, 1);
      core_end_tc_i = 1'b0;
      tick(1);
    end else begin
      core_end_tc_i = 1'b0;
      core_cipher_vld_i = 1'b1; core_cipher_i = c2;
      tick(1);
      core_cipher_vld_i = 1'b0;
    end
    core_end_tc_i = 1'b1;
    tick(1);
    wait_dv(d0 + 4);
    core_end_tc_i = 1'b0;
    core_end_final_i = 1'b1; core_tag_i = tg;
    tick(1);
    core_end_final_i = 1'b0;
    wait_tag(t0 + 1);
    chk("msg_starts", n_start - s0, 1);
    chk("msg_ct_count", n_ct - c0, 2);
    chk("msg_tag", tag_o, tg);
    chk("msg_ct_last", ct_data_o, c2);
    chk("msg_err", err_o, 0);
    chk("msg_idle", busy_o, 0);
    chk("msg_dv_log_len", dv_log.size() >= d0 + 4, 1);
    if (dv_log.size() >= d0 + 4) begin
      chk("dv_ad", dv_log[d0], ad);
      chk("dv_pt1", dv_log[d0+1], p1);
      chk("dv_pt2", dv_log[d0+2], p2);
      chk("dv_final_zero", dv_log[d0+3], 0);
    end
    if (ct_log.size() > c0) chk("ct_first", ct_log[c0], c1);
    tick(2);
  endtask

  task automatic err_case(input string tag, input logic [1:0] ty, input logic last);
    int d0 = n_dv;
    pulse_start();
    push(64'h0BAD, ty, last);
    core_end_init_i = 1'b1;
    tick(2);
    chk({tag, "_err"}, err_o, 1);
    chk({tag, "_no_pulse"}, n_dv, d0);
    chk({tag, "_ready_low"}, blk_ready_o, 0);
    chk({tag, "_not_busy"}, busy_o, 0);
    core_end_init_i = 1'b0;
    tick(2);
  endtask

  initial begin
    int d0;
    tick(3);
    chk("rst_busy", busy_o, 0);
    chk("rst_ready", blk_ready_o, 0);
    chk("rst_start", core_start_o, 0);
    chk("rst_dv", core_data_valid_o, 0);
    chk("rst_cdata", core_data_o, 0);
    chk("rst_ct", {ct_valid_o, ct_data_o}, 0);
    chk("rst_tag", {tag_valid_o, tag_o}, 0);
    chk("rst_err", err_o, 0);
    resetb_i = 1'b1;
    tick(2);

    // Host offers a block before start: must be refused.
    blk_data_i = 64'hEEEE; blk_type_i = BLK_AD; blk_last_i = 1'b1; blk_valid_i = 1'b1;
    tick(3);
    chk("idle_ready_low", blk_ready_o, 0);
    chk("idle_no_pulse", n_dv, 0);
    blk_valid_i = 1'b0;

    run_msg(64'h01, 64'hA1, 64'hA2, 64'hC1, 64'hC2, 128'hFEED_0001, 0, 1'b1, 1'b0);
    err_case("wrong_order", BLK_PT, 1'b0);
    run_msg(64'h11, 64'hB1, 64'hB2, 64'hD1, 64'hD2, 128'hFEED_0002, 0, 1'b0, 1'b0);
    run_msg(64'h21, 64'hE1, 64'hE2, 64'hF1, 64'hF2, 128'hFEED_0003, 0, 1'b0, 1'b1);
    run_msg(64'h31, 64'h51, 64'h52, 64'h61, 64'h62, 128'hFEED_0004, 20, 1'b0, 1'b0);
    err_case("illegal_type", 2'b10, 1'b1);
    err_case("ad_last_mismatch", BLK_AD, 1'b0);

    // Reset while the core is working on the first text block.
    d0 = n_dv;
    pulse_start();
    push(64'h41, BLK_AD, 1'b1);
    push(64'h71, BLK_PT, 1'b0);
    core_end_init_i = 1'b1;
    wait_dv(d0 + 1);
    core_end_init_i = 1'b0;
    core_end_da_i = 1'b1;
    wait_dv(d0 + 2);
    resetb_i = 1'b0;
    #1;
    chk("arst_busy", busy_o, 0);
    chk("arst_ready", blk_ready_o, 0);
    chk("arst_dv", {core_start_o, core_data_valid_o}, 0);
    chk("arst_cdata", core_data_o, 0);
    chk("arst_ct", {ct_valid_o, ct_data_o}, 0);
    chk("arst_tag", {tag_valid_o, tag_o}, 0);
    chk("arst_err", err_o, 0);
    core_end_da_i = 1'b0;
    tick(1);
    resetb_i = 1'b1;
    tick(1);
    run_msg(64'h81, 64'h91, 64'h92, 64'h93, 64'h94, 128'hFEED_0005, 0, 1'b0, 1'b0);

    // Ciphertext while idle is a protocol error.
    core_cipher_vld_i = 1'b1; core_cipher_i = 64'h77;
    tick(1);
    core_cipher_vld_i = 1'b0;
    chk("stray_ct_err", err_o, 1);
    chk("stray_ct_not_busy", busy_o, 0);
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
